// File: rtl/muldiv_unit_if.sv
// Execute-stage mult/div request, HI/LO write port and result/status bundle.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start_e;
    logic [1:0]       op_e;
    logic [WIDTH-1:0] src_a_e;
    logic [WIDTH-1:0] src_b_e;
    logic             flush_e;
    logic             hilo_access_d;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hilo_wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall_req;

    modport master (
        output start_e, op_e, src_a_e, src_b_e, flush_e, hilo_access_d,
               hi_we, lo_we, hilo_wdata,
        input  hi, lo, busy, done, stall_req
    );

    modport slave (
        input  start_e, op_e, src_a_e, src_b_e, flush_e, hilo_access_d,
               hi_we, lo_we, hilo_wdata,
        output hi, lo, busy, done, stall_req
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Latency: accept edge + 32 RUN edges; HI/LO and a one-cycle done land on the 32nd RUN edge.
// Backpressure: no new op while busy; stall_req holds Decode HI/LO consumers until done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    muldiv_unit_if.slave mif
);
    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [5:0]         cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   work_hi;
    logic [WIDTH-1:0]   work_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign accept = mif.start_e & ~mif.flush_e & (state == IDLE);
    assign sgn    = ~mif.op_e[0];
    assign a_neg  = sgn & mif.src_a_e[WIDTH-1];
    assign b_neg  = sgn & mif.src_b_e[WIDTH-1];
    assign a_mag  = a_neg ? -mif.src_a_e : mif.src_a_e;
    assign b_mag  = b_neg ? -mif.src_b_e : mif.src_b_e;

    // Multiply: work_hi:work_lo is the product register, multiplier shifts out of work_lo.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nxt;
    logic [WIDTH-1:0]   mul_lo_nxt;

    assign mul_sum    = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_hi_nxt = mul_sum[WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], work_lo[WIDTH-1:1]};

    // Divide: work_hi is the partial remainder, dividend bits shift out of work_lo as quotient bits shift in.
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               take;
    logic [WIDTH-1:0]   div_hi_nxt;
    logic [WIDTH-1:0]   div_lo_nxt;

    assign shifted    = {work_hi, work_lo[WIDTH-1]};
    assign diff       = shifted - {1'b0, opnd};
    assign take       = ~diff[WIDTH];
    assign div_hi_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign div_lo_nxt = {work_lo[WIDTH-2:0], take};

    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign step_hi  = is_div ? div_hi_nxt : mul_hi_nxt;
    assign step_lo  = is_div ? div_lo_nxt : mul_lo_nxt;
    assign product  = {step_hi, step_lo};
    assign prod_fix = neg_q ? -product : product;
    // Zero divisor: the remainder path already reproduces the dividend, only LO is forced.
    assign q_fix    = div_zero ? {WIDTH{1'b1}} : (neg_q ? -step_lo : step_lo);
    assign r_fix    = neg_r ? -step_hi : step_hi;
    assign res_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        busy_q   <= 1'b1;
                        cnt      <= '0;
                        is_div   <= mif.op_e[1];
                        neg_q    <= a_neg ^ b_neg;
                        work_hi  <= '0;
                        if (mif.op_e[1]) begin
                            opnd     <= b_mag;
                            work_lo  <= a_mag;
                            neg_r    <= a_neg;
                            div_zero <= (mif.src_b_e == '0);
                        end else begin
                            opnd     <= a_mag;
                            work_lo  <= b_mag;
                            neg_r    <= 1'b0;
                            div_zero <= 1'b0;
                        end
                    end else begin
                        if (mif.hi_we) hi_q <= mif.hilo_wdata;
                        if (mif.lo_we) lo_q <= mif.hilo_wdata;
                    end
                end
                RUN: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mif.hi        = hi_q;
    assign mif.lo        = lo_q;
    assign mif.busy      = busy_q;
    assign mif.done      = done_q;
    assign mif.stall_req = mif.hilo_access_d & (busy_q | accept);
endmodule
